// File: rtl/snax_csr_responder_pkg.sv
// Shared types and address helpers for the SNAX CSR responder.
// Response entries carry up to MaxDataWidth bits of read data.
package snax_csr_responder_pkg;

  localparam int unsigned MaxDataWidth = 64;

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
  } rsp_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } acc_state_t;

  // Launch sits right after the RO block; perf follows launch.
  function automatic int unsigned special_addr(
    input int unsigned num_rw,
    input int unsigned num_ro,
    input bit          perf
  );
    return perf ? num_rw + num_ro + 1 : num_rw + num_ro;
  endfunction

endpackage

// File: rtl/snax_csr_responder_if.sv
// CSR request/response bus between a host (master) and the responder (slave).
// Signal names follow the responder's port naming.
interface snax_csr_responder_if #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32
) ();

  logic [RegAddrWidth-1:0] csr_req_addr_i;
  logic [RegDataWidth-1:0] csr_req_data_i;
  logic                    csr_req_wen_i;
  logic                    csr_req_valid_i;
  logic                    csr_req_ready_o;
  logic [RegDataWidth-1:0] csr_rsp_data_o;
  logic                    csr_rsp_valid_o;
  logic                    csr_rsp_ready_i;

  modport master (
    output csr_req_addr_i,
    output csr_req_data_i,
    output csr_req_wen_i,
    output csr_req_valid_i,
    input  csr_req_ready_o,
    input  csr_rsp_data_o,
    input  csr_rsp_valid_o,
    output csr_rsp_ready_i
  );

  modport slave (
    input  csr_req_addr_i,
    input  csr_req_data_i,
    input  csr_req_wen_i,
    input  csr_req_valid_i,
    output csr_req_ready_o,
    output csr_rsp_data_o,
    output csr_rsp_valid_o,
    input  csr_rsp_ready_i
  );

endinterface

// File: rtl/snax_csr_rsp_fifo.sv
// Circular response buffer; head is presented combinationally.
// Push is honoured when full only together with a pop.
module snax_csr_rsp_fifo #(
  parameter int unsigned Depth  = 2,
  parameter type         DATA_T = logic [31:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  DATA_T push_data,
  input  logic  pop,
  output DATA_T pop_data,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  DATA_T           mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= incr(wr_ptr);
      if (do_pop)  rd_ptr <= incr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (!do_push && do_pop) count <= count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/snax_csr_responder.sv
// CSR responder: RW/RO register file, launch/busy control, buffered reads.
// Define SNAX_CSR_RESPONDER_PERF_CNT_EN to add a busy-cycle counter.
module snax_csr_responder #(
  parameter int unsigned NumRwCsr     = 8,
  parameter int unsigned NumRoCsr     = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RspDepth     = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  snax_csr_responder_if.slave                  csr,
  output logic [NumRwCsr-1:0][RegDataWidth-1:0] rw_csr_o,
  input  logic [NumRoCsr-1:0][RegDataWidth-1:0] ro_csr_i,
  output logic                                 start_o,
  input  logic                                 acc_done_i
);

  import snax_csr_responder_pkg::*;

  localparam int unsigned La = special_addr(NumRwCsr, NumRoCsr, 1'b0);
  localparam int unsigned Pa = special_addr(NumRwCsr, NumRoCsr, 1'b1);
  localparam int unsigned RwIdxW = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
  localparam int unsigned RoIdxW = (NumRoCsr > 1) ? $clog2(NumRoCsr) : 1;

  localparam logic [RegAddrWidth-1:0] RwEnd  = RegAddrWidth'(NumRwCsr);
  localparam logic [RegAddrWidth-1:0] LaAddr = RegAddrWidth'(La);
  localparam logic [RegAddrWidth-1:0] PaAddr = RegAddrWidth'(Pa);

  logic [NumRwCsr-1:0][RegDataWidth-1:0] rw_q;
  acc_state_t                            state_q;
  acc_state_t                            state_d;
  logic                                  start_q;
  logic                                  start_d;
  logic                                  busy;

  logic [RegAddrWidth-1:0] addr;
  logic [RwIdxW-1:0]       rw_idx;
  logic [RoIdxW-1:0]       ro_idx;
  logic                    is_rw;
  logic                    is_ro;
  logic                    is_la;
  logic                    is_pa;

  logic                    ready;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    launch;
  logic [RegDataWidth-1:0] rdata;
  logic [RegDataWidth-1:0] perf_val;

  rsp_entry_t push_entry;
  rsp_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign addr   = csr.csr_req_addr_i;
  assign rw_idx = addr[RwIdxW-1:0];
  assign ro_idx = RoIdxW'(addr - RwEnd);
  assign is_rw  = addr < RwEnd;
  assign is_ro  = (addr >= RwEnd) && (addr < LaAddr);
  assign is_la  = addr == LaAddr;
  assign is_pa  = addr == PaAddr;
  assign busy   = state_q == ST_BUSY;

  // Readiness looks only at registered state and the request itself.
  assign ready = !((busy && csr.csr_req_wen_i && (is_rw || is_la)) ||
                   (!csr.csr_req_wen_i && fifo_full));

  assign wr_fire = csr.csr_req_valid_i && ready && csr.csr_req_wen_i;
  assign rd_fire = csr.csr_req_valid_i && ready && !csr.csr_req_wen_i;
  assign launch  = wr_fire && is_la && csr.csr_req_data_i[0];

  assign csr.csr_req_ready_o = ready;
  assign rw_csr_o            = rw_q;
  assign start_o             = start_q;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_rw:   rdata = rw_q[rw_idx];
      is_ro:   rdata = ro_csr_i[ro_idx];
      is_la:   rdata = {{(RegDataWidth-1){1'b0}}, busy};
      is_pa:   rdata = perf_val;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rw_q <= '0;
    end else if (wr_fire && is_rw) begin
      rw_q[rw_idx] <= csr.csr_req_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (acc_done_i) state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
  logic [RegDataWidth-1:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (launch) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + RegDataWidth'(1);
    end
  end

  assign perf_val = perf_q;
`else
  assign perf_val = '0;
`endif

  assign push_entry.data = MaxDataWidth'(rdata);
  assign pop             = !fifo_empty && csr.csr_rsp_ready_i;

  snax_csr_rsp_fifo #(
    .Depth  (RspDepth),
    .DATA_T (rsp_entry_t)
  ) i_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rd_fire),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign csr.csr_rsp_valid_o = !fifo_empty;
  assign csr.csr_rsp_data_o  = RegDataWidth'(head.data);

endmodule

// File: tb/tb_snax_csr_responder.sv
// Scoreboard bench for snax_csr_responder with default parameters.
// LA = 10, PA = 11; expected read data is queued at accept time.
module tb_snax_csr_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snax_csr_responder_if #(.RegAddrWidth(32), .RegDataWidth(32)) bus ();

  logic [7:0][31:0] rw_csr;
  logic [1:0][31:0] ro_csr;
  logic             start;
  logic             acc_done;

  snax_csr_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr        (bus),
    .rw_csr_o   (rw_csr),
    .ro_csr_i   (ro_csr),
    .start_o    (start),
    .acc_done_i (acc_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc;
  logic [31:0] exp_q[$];

`ifdef SNAX_CSR_RESPONDER_PERF_CNT_EN
  localparam logic [31:0] PerfExp = 32'd5;
`else
  localparam logic [31:0] PerfExp = 32'd0;
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handed over must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.csr_rsp_valid_o && bus.csr_rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got 0x%08h expected none",
                 bus.csr_rsp_data_o);
      end else begin
        check("rsp_data", bus.csr_rsp_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] data,
                        input logic wen, input logic [31:0] exp,
                        output int acc_cyc);
    bus.csr_req_addr_i  = addr;
    bus.csr_req_data_i  = data;
    bus.csr_req_wen_i   = wen;
    bus.csr_req_valid_i = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.csr_req_ready_o) begin
        acc_cyc = cyc;
        if (!wen) exp_q.push_back(exp);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.csr_req_valid_i = 1'b0;
    bus.csr_req_wen_i   = 1'b0;
    if (acc_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: addr %0d got no accept expected accept", addr);
    end
  endtask

  // Write that must stall while busy and go through the cycle after done.
  task automatic blocked_write(input logic [31:0] addr,
                               input logic [31:0] data, input string name);
    int a;
    int dcyc;
    dcyc = 0;
    fork
      do_req(addr, data, 1'b1, 32'd0, a);
      begin
        repeat (3) @(posedge clk);
        #1;
        acc_done = 1'b1;
        dcyc = cyc;
        @(posedge clk);
        #1;
        acc_done = 1'b0;
      end
    join
    check(name, a, dcyc + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.csr_req_addr_i  = '0;
    bus.csr_req_data_i  = '0;
    bus.csr_req_wen_i   = 1'b0;
    bus.csr_req_valid_i = 1'b0;
    bus.csr_rsp_ready_i = 1'b1;
    acc_done            = 1'b0;
    ro_csr[0]           = 32'h0000_BEEF;
    ro_csr[1]           = 32'h0000_1234;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_rsp_valid", bus.csr_rsp_valid_o, 0);
    check("rst_start", start, 0);
    check("rst_ready", bus.csr_req_ready_o, 1);
    check("rst_rw_zero", rw_csr == '0, 1);
    @(posedge clk);
    #1;

    // Write then read back with one-cycle latency
    do_req(3, 32'hA5, 1'b1, 0, acc);
    @(negedge clk);
    check("rw3_update", rw_csr[3], 32'hA5);
    check("rsp_idle", bus.csr_rsp_valid_o, 0);
    @(posedge clk);
    #1;
    do_req(3, 0, 1'b0, 32'hA5, acc);
    @(negedge clk);
    check("rd_latency", bus.csr_rsp_valid_o, 1);
    @(posedge clk);
    #1;

    // Launch pulse, busy readback, stalled RW write
    do_req(10, 1, 1'b1, 0, acc);
    @(negedge clk);
    check("start_pulse", start, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("start_single", start, 0);
    @(posedge clk);
    #1;
    do_req(10, 0, 1'b0, 1, acc);
    blocked_write(0, 32'h77, "busy_wr_stall");
    @(negedge clk);
    check("rw0_update", rw_csr[0], 32'h77);
    @(posedge clk);
    #1;

    // Launch blocked by busy, released by done in the same cycle
    do_req(10, 1, 1'b1, 0, acc);
    blocked_write(10, 1, "blocked_launch");
    @(negedge clk);
    check("relaunch_start", start, 1);
    @(posedge clk);
    #1;
    acc_done = 1'b1;
    @(posedge clk);
    #1;
    acc_done = 1'b0;
    do_req(10, 0, 1'b0, 0, acc);

    // Backpressure: third read stalls on a full buffer
    do_req(1, 32'h11, 1'b1, 0, acc);
    do_req(2, 32'h22, 1'b1, 0, acc);
    drain();
    bus.csr_rsp_ready_i = 1'b0;
    do_req(0, 0, 1'b0, 32'h77, acc);
    do_req(1, 0, 1'b0, 32'h11, acc);
    fork
      do_req(2, 0, 1'b0, 32'h22, acc);
      begin
        repeat (3) @(negedge clk);
        check("full_stall", bus.csr_req_ready_o, 0);
        check("full_rsp_valid", bus.csr_rsp_valid_o, 1);
        @(posedge clk);
        #1;
        bus.csr_rsp_ready_i = 1'b1;
      end
    join
    drain();

    // RO, unmapped, and ignored RO write
    do_req(8, 0, 1'b0, 32'hBEEF, acc);
    do_req(9, 0, 1'b0, 32'h1234, acc);
    do_req(200, 0, 1'b0, 0, acc);
    do_req(9, 32'hDEAD, 1'b1, 0, acc);
    @(negedge clk);
    check("ro_wr_norsp", bus.csr_rsp_valid_o, 0);
    check("ro_wr_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
    do_req(9, 0, 1'b0, 32'h1234, acc);

    // Perf counter over five busy cycles
    do_req(10, 1, 1'b1, 0, acc);
    repeat (4) @(posedge clk);
    #1;
    acc_done = 1'b1;
    @(posedge clk);
    #1;
    acc_done = 1'b0;
    do_req(11, 0, 1'b0, PerfExp, acc);
    do_req(10, 0, 1'b0, 0, acc);
    acc_done = 1'b1;
    @(posedge clk);
    #1;
    acc_done = 1'b0;
    do_req(10, 0, 1'b0, 0, acc);
    drain();

    // Reset with buffered responses and busy set
    bus.csr_rsp_ready_i = 1'b0;
    do_req(5, 32'h55, 1'b1, 0, acc);
    do_req(10, 1, 1'b1, 0, acc);
    do_req(0, 0, 1'b0, 32'h77, acc);
    do_req(1, 0, 1'b0, 32'h11, acc);
    @(negedge clk);
    check("pre_rst_valid", bus.csr_rsp_valid_o, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.csr_rsp_valid_o, 0);
    check("mid_rst_rw_zero", rw_csr == '0, 1);
    check("mid_rst_start", start, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.csr_rsp_ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_start", start, 0);
    @(posedge clk);
    #1;
    do_req(10, 0, 1'b0, 0, acc);
    do_req(5, 0, 1'b0, 0, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snax_csr_responder.md
SNAX_CSR_RESPONDER -- requirements
Module: snax_csr_responder

Interface
REQ-001 SHALL have parameter NumRwCsr, default 8: number of read/write config registers at word addresses 0..NumRwCsr-1.
REQ-002 SHALL have parameter NumRoCsr, default 2: number of read-only status registers at addresses NumRwCsr..NumRwCsr+NumRoCsr-1.
REQ-003 SHALL have parameter RegDataWidth, default 32: CSR data width.
REQ-004 SHALL have parameter RegAddrWidth, default 32: CSR address width; the address is a word index.
REQ-005 SHALL have parameter RspDepth, default 2: response buffer depth, >=1.
REQ-006 SHALL use one clock and an asynchronous active-high reset: clk_i input 1 (all state on rising edge), rst_i input 1.
REQ-007 SHALL have the request ports csr_req_addr_i in RegAddrWidth, csr_req_data_i in RegDataWidth, csr_req_wen_i in 1 (1=write), csr_req_valid_i in 1, csr_req_ready_o out 1.
REQ-008 SHALL have the response ports csr_rsp_data_o out RegDataWidth, csr_rsp_valid_o out 1, csr_rsp_ready_i in 1.
REQ-009 SHALL have the accelerator ports rw_csr_o out NumRwCsr x RegDataWidth (register contents), ro_csr_i in NumRoCsr x RegDataWidth, start_o out 1 (launch pulse), acc_done_i in 1 (completion pulse).

Function
REQ-010 Launch address LA SHALL equal NumRwCsr+NumRoCsr; perf address PA SHALL equal LA+1.
REQ-011 A transfer SHALL occur when csr_req_valid_i and csr_req_ready_o are both 1 in the same cycle.
REQ-012 Writes SHALL produce no response; every accepted read SHALL push exactly one response.
REQ-013 Read data SHALL be: RW register value, ro_csr_i sampled at accept, {0..,busy} at LA, counter at PA (macro on), else 0.
REQ-014 Accepted write to a RW address SHALL update that register at the next edge; writes to RO, PA or unmapped addresses SHALL be accepted and ignored.
REQ-015 Accepted write to LA with data[0]=1 SHALL set busy and drive start_o=1 for exactly the following cycle; data[0]=0 SHALL be a no-op.
REQ-016 acc_done_i=1 while busy SHALL clear busy at the next edge; acc_done_i while idle SHALL be ignored.
REQ-017 csr_req_ready_o SHALL be 0 for any write to a RW address or LA while busy; writes to other addresses SHALL stay accepted.
REQ-018 csr_req_ready_o SHALL be 0 for a read while the response buffer is full; there SHALL be no same-cycle pop-to-push pass-through.
REQ-019 csr_req_ready_o SHALL depend only on registered state and the request address/wen, never on csr_rsp_ready_i.
REQ-020 Read latency SHALL be 1 cycle: read accepted at cycle N gives csr_rsp_valid_o=1 at cycle N+1 at the earliest.
REQ-021 Responses SHALL return in acceptance order.
REQ-022 csr_rsp_valid_o SHALL be 1 iff the buffer is non-empty; csr_rsp_data_o SHALL be the head entry and held stable while valid and not ready.
REQ-023 Simultaneous push and pop SHALL keep the occupancy unchanged, including when the buffer is full.
REQ-024 acc_done_i in the same cycle as a blocked launch SHALL clear busy; the launch SHALL be accepted in the next cycle.

Reset
REQ-025 rst_i SHALL asynchronously set all RW registers, busy and the counter to 0, set start_o=0 and csr_rsp_valid_o=0, and empty the buffer.
REQ-026 Reset mid-operation SHALL discard buffered responses and clear busy without emitting start_o.

Configuration
REQ-027 With SNAX_CSR_RESPONDER_PERF_CNT_EN defined, a RegDataWidth counter SHALL clear on launch, increment each busy cycle, wrap at 2^RegDataWidth and be readable at PA.
REQ-028 Without SNAX_CSR_RESPONDER_PERF_CNT_EN, the counter SHALL be absent and PA SHALL read as 0.

Structure
REQ-029 Package snax_csr_responder_pkg SHALL hold the rsp_entry_t typedef and a function computing LA/PA from NumRwCsr and NumRoCsr.
REQ-030 The response buffer SHALL be the sub-module snax_csr_rsp_fifo (parameters Depth and DATA_T; push/pop/full/empty).

Verification
REQ-031 Bench SHALL cover: write 0xA5 to addr 3, then read addr 3 -> rw_csr_o[3]=0xA5 at the next cycle and read rsp 0xA5 exactly 1 cycle after accept.
REQ-032 Bench SHALL cover: write LA data 1 -> start_o high exactly 1 cycle; write addr 0 while busy stalls until acc_done_i, then is accepted next cycle.
REQ-033 Bench SHALL cover: csr_rsp_ready_i=0 with 3 reads of addr 0,1,2 -> third read stalls (RspDepth=2); after release, responses arrive in order 0,1,2.
REQ-034 Bench SHALL cover: with ro_csr_i[1]=0x1234, read addr 9 -> 0x1234; read addr 200 -> 0; write addr 9 -> accepted with no response.
REQ-035 Bench SHALL cover, with the macro on: launch, 5 busy cycles, acc_done_i, read PA -> 5; with the macro off -> 0.
REQ-036 Bench SHALL cover: assert rst_i with 2 buffered responses and busy=1 -> csr_rsp_valid_o=0, busy read 0, rw_csr_o all 0.
